// File: rtl/bf16_accum.sv
//==============================================================================
// Module      : bf16_accum (with bf16_add)
// Description : Serial bf16 group reduction closed around one combinational adder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bf16_add #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 7
) (
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_a,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_b,
    output logic [EXP_WIDTH+SIG_WIDTH:0] o_sum
);
    localparam int c_W   = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int c_SW  = SIG_WIDTH + 1;
    localparam int c_AW  = c_SW + 3;
    localparam int c_LZW = $clog2(c_AW + 1);
    localparam int c_XW  = EXP_WIDTH + 2;
    localparam logic [c_XW-1:0] c_EMAX  = c_XW'((2 ** EXP_WIDTH) - 1);
    localparam logic [c_W-1:0]  c_QBIT  = {{(EXP_WIDTH + 2){1'b0}}, 1'b1, {(SIG_WIDTH - 1){1'b0}}};
    localparam logic [c_W-1:0]  c_DFNAN = {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH - 1){1'b0}}};

    logic                      w_a_sign, w_b_sign;
    logic [EXP_WIDTH-1:0]      w_a_exp, w_b_exp;
    logic [SIG_WIDTH-1:0]      w_a_man, w_b_man;
    logic                      w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [c_W-2:0]            w_a_mag, w_b_mag;
    logic                      w_swap;
    logic                      w_big_sign, w_eff_sub;
    logic [EXP_WIDTH-1:0]      w_big_exp, w_small_exp;
    logic [c_SW-1:0]           w_big_sig, w_small_sig;

    assign w_a_sign = i_a[c_W-1];
    assign w_b_sign = i_b[c_W-1];
    assign w_a_exp  = i_a[c_W-2:SIG_WIDTH];
    assign w_b_exp  = i_b[c_W-2:SIG_WIDTH];
    assign w_a_man  = i_a[SIG_WIDTH-1:0];
    assign w_b_man  = i_b[SIG_WIDTH-1:0];
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_nan  = (&w_a_exp) & (|w_a_man);
    assign w_b_nan  = (&w_b_exp) & (|w_b_man);
    assign w_a_inf  = (&w_a_exp) & ~(|w_a_man);
    assign w_b_inf  = (&w_b_exp) & ~(|w_b_man);

    // Subnormals are flushed: they enter the datapath as exact zeros.
    assign w_a_mag  = w_a_zero ? '0 : i_a[c_W-2:0];
    assign w_b_mag  = w_b_zero ? '0 : i_b[c_W-2:0];
    assign w_swap   = (w_b_mag > w_a_mag);

    assign w_big_sign  = w_swap ? w_b_sign : w_a_sign;
    assign w_eff_sub   = w_a_sign ^ w_b_sign;
    assign w_big_exp   = w_swap ? w_b_exp : w_a_exp;
    assign w_small_exp = w_swap ? w_a_exp : w_b_exp;
    assign w_big_sig   = w_swap ? (w_b_zero ? '0 : {1'b1, w_b_man})
                                : (w_a_zero ? '0 : {1'b1, w_a_man});
    assign w_small_sig = w_swap ? (w_a_zero ? '0 : {1'b1, w_a_man})
                                : (w_b_zero ? '0 : {1'b1, w_b_man});

    logic [EXP_WIDTH-1:0] w_diff;
    logic [31:0]          w_diff32;
    logic [c_AW-1:0]      w_small_ext, w_shifted, w_aligned, w_norm;
    logic                 w_sticky;
    logic [c_AW:0]        w_sum;
    logic [c_LZW-1:0]     w_lz;
    logic [c_XW-1:0]      w_exp_n, w_exp_r;
    logic                 w_uf, w_ovf, w_inc, w_res_zero;
    logic [c_SW-1:0]      w_keep;
    logic [c_SW:0]        w_rnd;
    logic [SIG_WIDTH-1:0] w_frac;
    logic [c_W-1:0]       w_finite;

    always_comb begin
        w_diff      = w_big_exp - w_small_exp;
        w_diff32    = 32'(w_diff);
        w_small_ext = {w_small_sig, 3'b000};
        w_sticky    = 1'b0;
        for (int i = 0; i < c_AW; i++) begin
            if (i < w_diff32) begin
                w_sticky = w_sticky | w_small_ext[i];
            end
        end
        w_shifted = w_small_ext >> w_diff;
        w_aligned = {w_shifted[c_AW-1:1], w_shifted[0] | w_sticky};

        if (w_eff_sub) begin
            w_sum = {1'b0, w_big_sig, 3'b000} - {1'b0, w_aligned};
        end else begin
            w_sum = {1'b0, w_big_sig, 3'b000} + {1'b0, w_aligned};
        end

        w_lz = c_LZW'(c_AW);
        for (int i = 0; i < c_AW; i++) begin
            if (w_sum[i]) begin
                w_lz = c_LZW'(c_AW - 1 - i);
            end
        end

        if (w_sum[c_AW]) begin
            w_norm  = {w_sum[c_AW:2], w_sum[1] | w_sum[0]};
            w_exp_n = {2'b00, w_big_exp} + c_XW'(1);
            w_uf    = 1'b0;
        end else begin
            w_norm  = w_sum[c_AW-1:0] << w_lz;
            w_exp_n = {2'b00, w_big_exp} - c_XW'(w_lz);
            w_uf    = ({2'b00, w_big_exp} <= c_XW'(w_lz));
        end

        // Round to nearest, ties to even, on guard/round/sticky.
        w_keep     = w_norm[c_AW-1:3];
        w_inc      = w_norm[2] & (w_norm[1] | w_norm[0] | w_keep[0]);
        w_rnd      = {1'b0, w_keep} + (c_SW + 1)'(w_inc);
        w_exp_r    = w_exp_n + c_XW'(w_rnd[c_SW]);
        w_frac     = w_rnd[c_SW] ? '0 : w_rnd[SIG_WIDTH-1:0];
        w_res_zero = ~(w_rnd[c_SW] | w_rnd[c_SW-1]);
        w_ovf      = (w_exp_r >= c_EMAX);

        if (w_res_zero || w_uf) begin
            w_finite = '0;
        end else if (w_ovf) begin
            w_finite = {w_big_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        end else begin
            w_finite = {w_big_sign, w_exp_r[EXP_WIDTH-1:0], w_frac};
        end
    end

    always_comb begin
        if (w_a_nan) begin
            o_sum = i_a | c_QBIT;
        end else if (w_b_nan) begin
            o_sum = i_b | c_QBIT;
        end else if (w_a_inf && w_b_inf && w_eff_sub) begin
            o_sum = c_DFNAN;
        end else if (w_a_inf) begin
            o_sum = i_a;
        end else if (w_b_inf) begin
            o_sum = i_b;
        end else begin
            o_sum = w_finite;
        end
    end
endmodule

module bf16_accum #(
    parameter int EXP_WIDTH  = 8,
    parameter int SIG_WIDTH  = 7,
    parameter int FLAG_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_data,
    input  logic                        i_last,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [EXP_WIDTH+SIG_WIDTH:0] o_data,
    output logic [FLAG_WIDTH-1:0]       o_flag,
    output logic [CNT_WIDTH-1:0]        o_count
);
    localparam int c_W    = EXP_WIDTH + SIG_WIDTH + 1;
    localparam int c_NAN  = 3;
    localparam int c_ZERO = 2;
    localparam int c_INF  = 1;
    localparam int c_NORM = 0;

    localparam logic [0:0] S_ACC  = 1'b0;
    localparam logic [0:0] S_DONE = 1'b1;

    logic [0:0]           r_state, w_state_nxt;
    logic [c_W-1:0]       r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [c_W-1:0]       w_sum;
    logic                 w_in_fire, w_out_fire;
    logic [EXP_WIDTH-1:0] w_exp;
    logic [SIG_WIDTH-1:0] w_man;

    bf16_add #(
        .EXP_WIDTH (EXP_WIDTH),
        .SIG_WIDTH (SIG_WIDTH)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (i_data),
        .o_sum (w_sum)
    );

    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ACC:   if (w_in_fire && i_last) w_state_nxt = S_DONE;
            S_DONE:  if (i_ready) w_state_nxt = S_ACC;
            default: w_state_nxt = S_ACC;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_ACC:   o_ready = 1'b1;
            S_DONE:  o_valid = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

    // Counter saturates; the sum keeps accumulating regardless.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_in_fire) begin
            r_acc <= w_sum;
            if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_out_fire) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

    assign o_data  = r_acc;
    assign o_count = r_cnt;
    assign w_exp   = r_acc[c_W-2:SIG_WIDTH];
    assign w_man   = r_acc[SIG_WIDTH-1:0];

    always_comb begin
        o_flag = '0;
        if (&w_exp) begin
            if (|w_man) o_flag[c_NAN] = 1'b1;
            else        o_flag[c_INF] = 1'b1;
        end else if (w_exp == '0) begin
            o_flag[c_ZERO] = 1'b1;
        end else begin
            o_flag[c_NORM] = 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_bf16_accum.sv
//==============================================================================
// Module      : tb_bf16_accum
// Description : Directed self-checking bench for bf16_accum.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bf16_accum;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_data = 16'h0000;
    logic        i_last = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_data;
    logic [3:0]  o_flag;
    logic [15:0] o_count;

    int total = 0;
    int bad   = 0;

    bf16_accum dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_flag  (o_flag),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] d, input logic [3:0] f,
                           input logic [15:0] c);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_data"},  32'(o_data),  32'(d));
        chk({tag, "_flag"},  32'(o_flag),  32'(f));
        chk({tag, "_count"}, 32'(o_count), 32'(c));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_data",  32'(o_data),  32'h0000);
        chk("rst_flag",  32'(o_flag),  32'b0100);
        chk("rst_count", 32'(o_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1.0 + 2.0
        beat(16'h3F80, 1'b0);
        beat(16'h4000, 1'b1);
        chk_res("two", 16'h4040, 4'b0001, 16'd2);
        tick();
        chk("two_ready_back", 32'(o_ready), 32'd1);
        chk("two_valid_low",  32'(o_valid), 32'd0);
        chk("two_acc_clear",  32'(o_data),  32'h0000);

        beat(16'h3F80, 1'b0);
        beat(16'hBF80, 1'b0);
        beat(16'h4000, 1'b1);
        chk_res("cancel3", 16'h4000, 4'b0001, 16'd3);
        tick();
        beat(16'h3F80, 1'b0);
        beat(16'hBF80, 1'b1);
        chk_res("cancel2", 16'h0000, 4'b0100, 16'd2);
        tick();

        beat(16'h7F80, 1'b0);
        beat(16'hFF80, 1'b1);
        chk_res("infinf", 16'hFFC0, 4'b1000, 16'd2);
        tick();
        beat(16'h7FC0, 1'b0);
        beat(16'h3F80, 1'b0);
        beat(16'h4000, 1'b1);
        chk_res("nan", 16'h7FC0, 4'b1000, 16'd3);
        tick();

        // Backpressure with a pending beat that must not be consumed
        i_ready = 1'b0;
        beat(16'h4040, 1'b1);
        i_valid = 1'b1;
        i_data  = 16'h3F80;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_res("bp_hold", 16'h4040, 4'b0001, 16'd1);
        end
        i_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        chk("bp_release_count", 32'(o_count), 32'd0);
        tick();
        chk("bp_beat_taken_data",  32'(o_data),  32'h3F80);
        chk("bp_beat_taken_count", 32'(o_count), 32'd1);
        beat(16'h4000, 1'b1);
        chk_res("bp_group", 16'h4040, 4'b0001, 16'd2);
        tick();

        // Back-to-back with i_valid held high
        i_valid = 1'b1;
        i_data  = 16'h3F80;
        i_last  = 1'b1;
        tick();
        chk_res("b2b_first", 16'h3F80, 4'b0001, 16'd1);
        i_data = 16'h4000;
        i_last = 1'b0;
        tick();
        chk("b2b_idle_ready", 32'(o_ready), 32'd1);
        chk("b2b_idle_count", 32'(o_count), 32'd0);
        tick();
        chk("b2b_second_beat", 32'(o_count), 32'd1);
        i_last = 1'b1;
        tick();
        chk_res("b2b_second", 16'h4080, 4'b0001, 16'd2);
        i_valid = 1'b0;
        i_last  = 1'b0;
        tick();

        // Asynchronous reset mid-group
        beat(16'h3F80, 1'b0);
        beat(16'h4000, 1'b0);
        chk("mid_count_pre", 32'(o_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_data",  32'(o_data),  32'h0000);
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        #3 rst_n = 1'b1;
        tick();
        beat(16'h4040, 1'b1);
        chk_res("post_rst", 16'h4040, 4'b0001, 16'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
